// File: rtl/fpro_usb_gpx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpro_usb_gpx_pkg
// Description : Shared register map, bit indices and debounce state encoding
//               for the GPX event controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fpro_usb_gpx_pkg;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_EVENT  = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int CTRL_RISE_EN   = 0;
    localparam int CTRL_FALL_EN   = 1;
    localparam int CTRL_IRQ_EN    = 2;

    localparam int STAT_LEVEL     = 0;
    localparam int STAT_PENDING   = 1;
    localparam int STAT_OVERFLOW  = 2;

    localparam int EVT_CLR_PEND   = 0;
    localparam int EVT_CLR_OVF    = 1;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        LOW_QUAL    = 2'd1,
        HIGH_STABLE = 2'd2,
        HIGH_QUAL   = 2'd3
    } gpx_db_state_e;

    typedef struct packed {
        logic irq_en;
        logic fall_en;
        logic rise_en;
    } gpx_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/fpro_gpx_debounce.sv
`default_nettype none
// ============================================================================
// Module      : fpro_gpx_debounce
// Description : 2-FF synchroniser plus qualification FSM producing a filtered
//               level and one-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module fpro_gpx_debounce
    import fpro_usb_gpx_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Entering a QUAL state already accounts for one stable sample, so the
    // last count is DEBOUNCE_CYCLES-2; a single-cycle filter skips QUAL.
    localparam logic [CW-1:0] QUAL_LAST = (DEBOUNCE_CYCLES >= 2) ? CW'(DEBOUNCE_CYCLES - 2) : '0;
    localparam bit            DIRECT    = (DEBOUNCE_CYCLES <= 1);

    logic          sync1_q;
    logic          sync2_q;
    gpx_db_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            case (state_q)
                LOW_STABLE: begin
                    if (sync2_q) begin
                        cnt_q <= '0;
                        if (DIRECT) begin
                            state_q <= HIGH_STABLE;
                            level_q <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            state_q <= LOW_QUAL;
                        end
                    end
                end
                LOW_QUAL: begin
                    if (!sync2_q) begin
                        state_q <= LOW_STABLE;
                    end else if (cnt_q == QUAL_LAST) begin
                        state_q <= HIGH_STABLE;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HIGH_STABLE: begin
                    if (!sync2_q) begin
                        cnt_q <= '0;
                        if (DIRECT) begin
                            state_q <= LOW_STABLE;
                            level_q <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            state_q <= HIGH_QUAL;
                        end
                    end
                end
                HIGH_QUAL: begin
                    if (sync2_q) begin
                        state_q <= HIGH_STABLE;
                    end else if (cnt_q == QUAL_LAST) begin
                        state_q <= LOW_STABLE;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= LOW_STABLE;
            endcase
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/fpro_usb_gpx_evt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fpro_usb_gpx_evt_ctrl
// Description : Avalon-MM GPX event controller: edge latch, overflow, event
//               counter, level IRQ and registered read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module fpro_usb_gpx_evt_ctrl
    import fpro_usb_gpx_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_port,
    output logic        irq
);

    logic             level;
    logic             rise;
    logic             fall;

    gpx_ctrl_t        ctrl_q;
    logic             pending_q;
    logic             overflow_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             irq_q;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;

    logic             wr_en;
    logic             evt;
    logic             clr_pend;
    logic             clr_ovf;
    logic             cnt_clr;
    logic             unused_wdata;

    fpro_gpx_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_i   (in_port),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign wr_en        = chipselect & ~write_n;
    assign evt          = (rise & ctrl_q.rise_en) | (fall & ctrl_q.fall_en);
    assign clr_pend     = wr_en && (address == ADDR_EVENT) && writedata[EVT_CLR_PEND];
    assign clr_ovf      = wr_en && (address == ADDR_EVENT) && writedata[EVT_CLR_OVF];
    assign cnt_clr      = wr_en && (address == ADDR_COUNT);
    assign unused_wdata = ^writedata[31:3];

    // A clear coinciding with an event still records that event.
    always_comb begin
        count_d = count_q;
        if (cnt_clr) begin
            count_d = evt ? CNT_W'(1) : '0;
        end else if (evt && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_STATUS: begin
                rdata_d[STAT_LEVEL]    = level;
                rdata_d[STAT_PENDING]  = pending_q;
                rdata_d[STAT_OVERFLOW] = overflow_q;
            end
            ADDR_CTRL:   rdata_d[2:0] = ctrl_q;
            ADDR_EVENT:  rdata_d[1:0] = {overflow_q, pending_q};
            ADDR_COUNT:  rdata_d      = 32'(count_q);
            default:     rdata_d      = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (wr_en && (address == ADDR_CTRL)) begin
                ctrl_q <= gpx_ctrl_t'(writedata[2:0]);
            end

            if (evt) begin
                pending_q <= 1'b1;
            end else if (clr_pend) begin
                pending_q <= 1'b0;
            end

            if (evt && pending_q && !clr_pend) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end

            count_q <= count_d;
            irq_q   <= ctrl_q.irq_en & pending_q;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire
